vga_dither_out: RTL and testbench
=================================

# vga_dither_out

Parametrised VGA output stage between `system` and the board's VGA DAC pins. Reduces IN_W-bit RGB to the board's OUT_W-bit resistor DAC, replacing plain MSB truncation with a 4x4 ordered (Bayer) dither. Delays hsync, vsync and display-enable to stay aligned with the colour pipeline. One instance drives all three channels plus sync on `clk_vga`.

## Interface
- IN_W, 6, input colour width per channel; requires IN_W > OUT_W.
- OUT_W, 3, output colour width per channel; requires 1 <= IN_W-OUT_W <= 8.
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level (0 = active-low).
- clk_vga  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- r_in, g_in, b_in  in  IN_W each  pixel colour, valid when de_in=1.
- de_in  in  1  display enable (1 = visible pixel).
- hsync_in, vsync_in  in  1 each  syncs at HS_POL/VS_POL levels.
- r_out, g_out, b_out  out  OUT_W each  reduced colour to DAC pins.
- de_out  out  1  delayed de_in.
- hsync_out, vsync_out  out  1 each  delayed syncs, polarity unchanged.

## Operation
- D = IN_W-OUT_W.
- Position counters:
  - x: 2-bit; increments each cycle de_in=1; cleared when de_in=0; wraps 3->0.
  - y: 2-bit; increments on de_in falling edge; wraps 3->0; cleared in the cycle vsync_in enters its active level. Clear beats increment when both coincide.
- Threshold t = B[y][x], 4-bit Bayer matrix, x indexes columns:
  - row0: 0 8 2 10
  - row1: 12 4 14 6
  - row2: 3 11 1 9
  - row3: 15 7 13 5
- Offset o = t << (D-4) if D >= 4, else t >> (4-D). Width D bits, so o < 2^D.
- Per channel:
  - sum = c + o in IN_W+1 bits.
  - If sum[IN_W]=1, saturate to all ones.
  - Output = saturated sum[IN_W-1:D].
  - The same t applies to all three channels.
- Blanking: when the delayed de is 0, r/g/b_out = 0 regardless of input.
- No handshake; one pixel accepted per cycle, no stalls.

## Timing
- Pipeline of 2 registers:
  - Stage 1: registers inputs and t.
  - Stage 2: registers the saturated, reduced result.
- Latency: r/g/b_out, de_out, hsync_out and vsync_out all lag their inputs by exactly 2 clk_vga cycles.
- Reset values (asynchronous, immediate):
  - r/g/b_out = 0, de_out = 0
  - hsync_out = ~HS_POL, vsync_out = ~VS_POL
  - x = 0, y = 0, all pipeline registers cleared.
- Reset released mid-frame: counters restart from 0. The first 2 output cycles after release show reset values, then track inputs.
- de_in asserted for one cycle: x=0 for that pixel; it is output once, 2 cycles later.
- Line shorter than 4 pixels: y still increments once on the falling edge.

## Configuration
- Macro `VGA_DITHER_EN`.
- Defined: ordered dither as in Operation.
- Undefined:
  - Counters and Bayer table are not built.
  - Output = c[IN_W-1:D] (pure truncation).
  - Latency stays 2 cycles; blanking and sync behaviour are identical.

## Test plan
Defaults IN_W=6, OUT_W=3 (D=3, o = t>>1), macro defined unless stated.

- Reset held, inputs toggling -> r/g/b_out=0, de_out=0, hsync_out=1, vsync_out=1. After release, first input pixel appears 2 cycles later.
- Macro undefined, de_in=1, r_in=6'h2F -> r_out=3'd5 exactly 2 cycles later; g/b likewise truncated.
- vsync pulse then first line:
  - pixel x=0, r_in=6'h2F (t=0) -> r_out=5
  - pixel x=1 (t=8, o=4): 0x2F+4=0x33 -> r_out=6
- Saturation: x=1, r_in=6'h3F -> sum 0x43 overflows -> r_out=7, no wrap to 0.
- Blanking: de_in=0 with r/g/b_in=6'h3F -> r/g/b_out=0, de_out=0, syncs pass through with 2-cycle delay.
- Row advance:
  - after one full line, second line x=0 (t=12, o=6): r_in=6'h02 -> sum 8 -> r_out=1.
  - assert vsync coincident with a de_in falling edge -> next line uses row0 (clear wins).

Source files
------------

// File: rtl/vga_dither_out.sv
// vga_dither_out: VGA output stage reducing IN_W-bit RGB to OUT_W-bit DAC
// codes, with hsync/vsync/de delayed to match the 2-stage colour pipeline.
// Optional feature macro: VGA_DITHER_EN
//   defined   -> 4x4 ordered (Bayer) dither before reduction
//   undefined -> plain MSB truncation; no position counters or table built
module vga_dither_out #(
   parameter int IN_W   = 6,
   parameter int OUT_W  = 3,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0
) (
   input  logic             clk_vga,
   input  logic             reset,
   input  logic [IN_W-1:0]  r_in,
   input  logic [IN_W-1:0]  g_in,
   input  logic [IN_W-1:0]  b_in,
   input  logic             de_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [OUT_W-1:0] r_out,
   output logic [OUT_W-1:0] g_out,
   output logic [OUT_W-1:0] b_out,
   output logic             de_out,
   output logic             hsync_out,
   output logic             vsync_out
);

   localparam int D   = IN_W - OUT_W;
   localparam int OW1 = OUT_W + 1;

   // stage 1: registered inputs
   logic [IN_W-1:0]  r_r1, r_g1, r_b1;
   logic             r_de1, r_hs1, r_vs1;

   // stage 2: registered outputs
   logic [OUT_W-1:0] r_r2, r_g2, r_b2;
   logic             r_de2, r_hs2, r_vs2;

   // reduced colour feeding stage 2
   logic [OUT_W-1:0] w_r_red, w_g_red, w_b_red;

`ifdef VGA_DITHER_EN
   logic [1:0] r_x, r_y;
   logic [3:0] r_t1;
   logic       w_de_fall, w_vs_start;

   // 4x4 Bayer threshold; x selects the column, y the row
   function automatic logic [3:0] f_bayer(input logic [1:0] i_y, input logic [1:0] i_x);
      logic [3:0] v_t;
      case ({i_y, i_x})
         4'h0: v_t = 4'd0;   4'h1: v_t = 4'd8;   4'h2: v_t = 4'd2;   4'h3: v_t = 4'd10;
         4'h4: v_t = 4'd12;  4'h5: v_t = 4'd4;   4'h6: v_t = 4'd14;  4'h7: v_t = 4'd6;
         4'h8: v_t = 4'd3;   4'h9: v_t = 4'd11;  4'hA: v_t = 4'd1;   4'hB: v_t = 4'd9;
         default: begin
            case (i_x)
               2'd0:    v_t = 4'd15;
               2'd1:    v_t = 4'd7;
               2'd2:    v_t = 4'd13;
               default: v_t = 4'd5;
            endcase
         end
      endcase
      return v_t;
   endfunction

   // add the scaled threshold, keep the top OUT_W bits, saturate on carry-out
   function automatic logic [OUT_W-1:0] f_reduce(input logic [IN_W-1:0] i_c, input logic [3:0] i_t);
      logic [D-1:0] v_o;
      logic [OUT_W:0] v_hi;
      // t scaled to D bits: t<<(D-4) or t>>(4-D), both equal (t*2^D)/16
      v_o  = D'({i_t, {D{1'b0}}} >> 4);
      v_hi = OW1'(({1'b0, i_c} + {{OW1{1'b0}}, v_o}) >> D);
      return v_hi[OUT_W] ? {OUT_W{1'b1}} : v_hi[OUT_W-1:0];
   endfunction

   // de falling edge advances the row; vsync entering its active level restarts it
   assign w_de_fall  = r_de1 & ~de_in;
   assign w_vs_start = (vsync_in == VS_POL) && (r_vs1 != VS_POL);

   // pixel position counters and stage-1 threshold register
   // NOTE: async reset is in the sensitivity list; all state uses <= so every
   //       register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         r_x  <= 2'd0;
         r_y  <= 2'd0;
         r_t1 <= 4'd0;
      end else begin
         r_t1 <= f_bayer(r_y, r_x);
         r_x  <= de_in ? r_x + 2'd1 : 2'd0;
         if (w_vs_start)
            r_y <= 2'd0;
         else if (w_de_fall)
            r_y <= r_y + 2'd1;
      end
   end

   // dithered reduction of stage-1 colour
   always_comb begin
      w_r_red = f_reduce(r_r1, r_t1);
      w_g_red = f_reduce(r_g1, r_t1);
      w_b_red = f_reduce(r_b1, r_t1);
   end
`else
   // plain truncation of stage-1 colour to its top OUT_W bits
   always_comb begin
      w_r_red = r_r1[IN_W-1:D];
      w_g_red = r_g1[IN_W-1:D];
      w_b_red = r_b1[IN_W-1:D];
   end
`endif

   // stage 1: capture pixel and sync inputs; syncs reset to their idle level
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         r_r1  <= '0;
         r_g1  <= '0;
         r_b1  <= '0;
         r_de1 <= 1'b0;
         r_hs1 <= ~HS_POL;
         r_vs1 <= ~VS_POL;
      end else begin
         r_r1  <= r_in;
         r_g1  <= g_in;
         r_b1  <= b_in;
         r_de1 <= de_in;
         r_hs1 <= hsync_in;
         r_vs1 <= vsync_in;
      end
   end

   // stage 2: register reduced colour, forced to black while blanked
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         r_r2  <= '0;
         r_g2  <= '0;
         r_b2  <= '0;
         r_de2 <= 1'b0;
         r_hs2 <= ~HS_POL;
         r_vs2 <= ~VS_POL;
      end else begin
         r_r2  <= r_de1 ? w_r_red : '0;
         r_g2  <= r_de1 ? w_g_red : '0;
         r_b2  <= r_de1 ? w_b_red : '0;
         r_de2 <= r_de1;
         r_hs2 <= r_hs1;
         r_vs2 <= r_vs1;
      end
   end

   assign r_out     = r_r2;
   assign g_out     = r_g2;
   assign b_out     = r_b2;
   assign de_out    = r_de2;
   assign hsync_out = r_hs2;
   assign vsync_out = r_vs2;

endmodule

// File: tb/tb_vga_dither_out.sv
// Testbench for vga_dither_out: directed steps plus randomized lines, checked
// against a pixel-level model (run length / line count, Bayer table, clamp).
module tb_vga_dither_out;

   localparam int IN_W   = 6;
   localparam int OUT_W  = 3;
   localparam int D      = IN_W - OUT_W;
   localparam bit HS_POL = 1'b0;
   localparam bit VS_POL = 1'b0;
   localparam int HS_ACT = HS_POL ? 1 : 0;
   localparam int HS_IDL = HS_POL ? 0 : 1;
   localparam int VS_ACT = VS_POL ? 1 : 0;
   localparam int VS_IDL = VS_POL ? 0 : 1;

`ifdef VGA_DITHER_EN
   localparam int LIT_X1_2F = 6;  // 0x2F + 4 = 0x33 -> 6
   localparam int LIT_Y1_02 = 1;  // 0x02 + 6 = 0x08 -> 1
`else
   localparam int LIT_X1_2F = 5;
   localparam int LIT_Y1_02 = 0;
`endif

   logic             clk_vga = 1'b0;
   logic             reset;
   logic [IN_W-1:0]  r_in, g_in, b_in;
   logic             de_in, hsync_in, vsync_in;
   logic [OUT_W-1:0] r_out, g_out, b_out;
   logic             de_out, hsync_out, vsync_out;

   vga_dither_out #(
      .IN_W(IN_W), .OUT_W(OUT_W), .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .clk_vga(clk_vga), .reset(reset),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   always #5 clk_vga = ~clk_vga;

   typedef struct {
      int r, g, b, de, hs, vs, lit_r;
   } exp_t;

   exp_t q[$];
   int   bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
   int   run, lines, prev_de, prev_vs;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // colour a pixel of value c takes at threshold t
   function automatic int model_colour(input int c, input int t);
`ifdef VGA_DITHER_EN
      int o, s;
      o = (t * (1 << D)) / 16;
      s = c + o;
      if (s > (1 << IN_W) - 1) s = (1 << IN_W) - 1;
      return s >> D;
`else
      if (t < 0) return 0;
      return c >> D;
`endif
   endfunction

   function automatic exp_t idle_entry();
      exp_t e;
      e.r = 0; e.g = 0; e.b = 0; e.de = 0;
      e.hs = HS_IDL; e.vs = VS_IDL; e.lit_r = -1;
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      q.push_back(idle_entry());
      run = 0; lines = 0; prev_de = 0; prev_vs = VS_IDL;
   endtask

   // drive one input cycle, predict its output, advance a clock, check oldest prediction
   task automatic step(input int de, input int hs, input int vs,
                       input int r, input int g, input int b, input int lit_r = -1);
      exp_t e;
      int   t;
      de_in = 1'(de); hsync_in = 1'(hs); vsync_in = 1'(vs);
      r_in = IN_W'(r); g_in = IN_W'(g); b_in = IN_W'(b);
      t = 0;
      if (de != 0) begin
         t = bayer[lines % 4][run % 4];
         run++;
      end else begin
         run = 0;
      end
      if (vs == VS_ACT && prev_vs != VS_ACT) lines = 0;
      else if (prev_de != 0 && de == 0) lines++;
      prev_de = de; prev_vs = vs;
      e.de = de; e.hs = hs; e.vs = vs; e.lit_r = lit_r;
      e.r = (de != 0) ? model_colour(r, t) : 0;
      e.g = (de != 0) ? model_colour(g, t) : 0;
      e.b = (de != 0) ? model_colour(b, t) : 0;
      q.push_back(e);
      @(posedge clk_vga); #1;
      e = q.pop_front();
      chk("r_out", 32'(r_out), e.r);
      chk("g_out", 32'(g_out), e.g);
      chk("b_out", 32'(b_out), e.b);
      chk("de_out", 32'(de_out), e.de);
      chk("hsync_out", 32'(hsync_out), e.hs);
      chk("vsync_out", 32'(vsync_out), e.vs);
      if (e.lit_r >= 0) chk("r_out_literal", 32'(r_out), e.lit_r);
   endtask

   task automatic blank(input int n, input int hs, input int vs);
      for (int i = 0; i < n; i++) step(0, hs, vs, 6'h3F, 6'h3F, 6'h3F);
   endtask

   initial begin
      reset = 1'b1;
      de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      r_in = '0; g_in = '0; b_in = '0;

      // reset held with toggling inputs: outputs stay at reset values
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_vga);
         de_in = ~de_in; hsync_in = ~hsync_in; vsync_in = ~vsync_in;
         r_in = IN_W'($urandom); g_in = IN_W'($urandom); b_in = IN_W'($urandom);
         @(posedge clk_vga); #1;
         chk("rst_r_out", 32'(r_out), 0);
         chk("rst_g_out", 32'(g_out), 0);
         chk("rst_b_out", 32'(b_out), 0);
         chk("rst_de_out", 32'(de_out), 0);
         chk("rst_hsync_out", 32'(hsync_out), HS_IDL);
         chk("rst_vsync_out", 32'(vsync_out), VS_IDL);
      end
      reset = 1'b0;
      model_reset();

      // first pixel after release emerges 2 cycles later
      step(1, HS_IDL, VS_IDL, 6'h2F, 6'h2F, 6'h2F, 5);
      step(1, HS_IDL, VS_IDL, 6'h2F, 6'h10, 6'h07, LIT_X1_2F);
      blank(3, HS_IDL, VS_IDL);

      // vsync pulse, hsync pulse, then first line (row 0)
      blank(2, HS_IDL, VS_ACT);
      blank(2, HS_ACT, VS_IDL);
      blank(1, HS_IDL, VS_IDL);
      step(1, HS_IDL, VS_IDL, 6'h2F, 6'h2F, 6'h2F, 5);
      step(1, HS_IDL, VS_IDL, 6'h2F, 6'h2F, 6'h2F, LIT_X1_2F);
      step(1, HS_IDL, VS_IDL, 6'h15, 6'h22, 6'h3E);
      step(1, HS_IDL, VS_IDL, 6'h31, 6'h0C, 6'h3D);
      step(1, HS_IDL, VS_IDL, 6'h08, 6'h3F, 6'h00);
      blank(2, HS_ACT, VS_IDL);
      // second line (row 1), x=0: t=12, o=6
      step(1, HS_IDL, VS_IDL, 6'h02, 6'h02, 6'h02, LIT_Y1_02);
      step(1, HS_IDL, VS_IDL, 6'h3F, 6'h1A, 6'h29);
      blank(2, HS_ACT, VS_IDL);

      // new frame: saturation at x=1 of row 0
      blank(2, HS_IDL, VS_ACT);
      blank(1, HS_IDL, VS_IDL);
      step(1, HS_IDL, VS_IDL, 6'h00, 6'h00, 6'h00);
      step(1, HS_IDL, VS_IDL, 6'h3F, 6'h3F, 6'h3F, 7);
      step(1, HS_IDL, VS_IDL, 6'h3F, 6'h3F, 6'h3F, 7);
      // vsync onset coincident with de falling edge: clear wins
      step(0, HS_IDL, VS_ACT, 6'h3F, 6'h3F, 6'h3F, 0);
      blank(1, HS_IDL, VS_ACT);
      blank(2, HS_IDL, VS_IDL);
      step(1, HS_IDL, VS_IDL, 6'h02, 6'h02, 6'h02, 0);
      step(1, HS_IDL, VS_IDL, 6'h1B, 6'h2C, 6'h05);
      blank(1, HS_IDL, VS_IDL);

      // single-pixel lines advance the row once each
      for (int i = 0; i < 3; i++) begin
         step(1, HS_IDL, VS_IDL, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)));
         blank(2, HS_IDL, VS_IDL);
      end

      // reset asserted mid-line, released mid-line: counters restart
      step(1, HS_IDL, VS_IDL, 6'h11, 6'h22, 6'h33);
      step(1, HS_IDL, VS_IDL, 6'h11, 6'h22, 6'h33);
      reset = 1'b1;
      #1;
      chk("midrst_r_out", 32'(r_out), 0);
      chk("midrst_de_out", 32'(de_out), 0);
      chk("midrst_hsync_out", 32'(hsync_out), HS_IDL);
      @(posedge clk_vga); #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++)
         step(1, HS_IDL, VS_IDL, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)));
      blank(2, HS_ACT, VS_IDL);

      // randomized frames of variable-length lines
      for (int ln = 0; ln < 40; ln++) begin
         if ($urandom_range(0, 7) == 0) begin
            blank(int'($urandom_range(1, 3)), HS_IDL, VS_ACT);
            blank(1, HS_IDL, VS_IDL);
         end
         blank(int'($urandom_range(1, 2)), HS_ACT, VS_IDL);
         blank(int'($urandom_range(0, 2)), HS_IDL, VS_IDL);
         for (int px = 0; px < int'($urandom_range(1, 9)); px++)
            step(1, HS_IDL, VS_IDL, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)));
      end
      blank(3, HS_IDL, VS_IDL);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
